// File: rtl/v810_busarb.sv
// v810_busarb: arbitrates NCH requester channels onto the single external
// V810 bus and runs the BCYSTn/READYn bus cycle, including SZRQn half-word
// sizing with an automatic second cycle for the upper half.
// Optional feature macro: V810_BUSARB_ROUND_ROBIN_EN selects round-robin
// arbitration; when undefined, the lowest-index requester wins.
module v810_busarb #(
    parameter int NCH = 2
) (
    input  logic              CLK,
    input  logic              RESn,
    input  logic              CE,
    input  logic [NCH-1:0]    CH_REQ,
    input  logic [NCH*32-1:0] CH_A,
    input  logic [NCH*32-1:0] CH_DO,
    input  logic [NCH*4-1:0]  CH_BE,
    input  logic [NCH-1:0]    CH_WR,
    input  logic [NCH-1:0]    CH_MRQ,
    input  logic [NCH*2-1:0]  CH_ST,
    output logic [NCH-1:0]    CH_ACK,
    output logic [31:0]       CH_DI,
    output logic [31:0]       A,
    input  logic [31:0]       D_I,
    output logic [31:0]       D_O,
    output logic [3:0]        BEn,
    output logic [1:0]        ST,
    output logic              DAn,
    output logic              MRQn,
    output logic              RW,
    output logic              BCYSTn,
    input  logic              READYn,
    input  logic              SZRQn
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, T1, T2, DONE} state_t;

    state_t         state, state_n;
    logic [GW-1:0]  grant, grant_n;
    logic [1:0]     be_hi, be_hi_n;
    logic           upper, upper_n;

    logic [31:0]    a_n, d_o_n, ch_di_n;
    logic [3:0]     ben_n;
    logic [1:0]     st_n;
    logic           dan_n, mrqn_n, rw_n, bcystn_n;
    logic [NCH-1:0] ack_n;

    logic           req_any;
    logic [GW-1:0]  win;
    logic [31:0]    sel_a, sel_do;
    logic [3:0]     sel_be;
    logic           sel_wr, sel_mrq;
    logic [1:0]     sel_st;

    assign req_any = |CH_REQ;

`ifdef V810_BUSARB_ROUND_ROBIN_EN
    logic [GW-1:0]    rr_ptr, rr_ptr_n;
    logic [2*NCH-1:0] req_rot;
    logic             rr_found;
    int               rr_idx;
    int               rr_nxt;

    // Round-robin pick: rotate requests so the search starts at rr_ptr
    always_comb begin
        req_rot  = {CH_REQ, CH_REQ} >> rr_ptr;
        win      = '0;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 0; k < NCH; k++) begin
            if (!rr_found && req_rot[k]) begin
                rr_idx = int'(rr_ptr) + k;
                if (rr_idx >= NCH) rr_idx = rr_idx - NCH;
                win      = GW'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end

    // Next search start is the channel after the one granted this cycle
    always_comb begin
        rr_ptr_n = rr_ptr;
        rr_nxt   = 0;
        if (state == IDLE && req_any) begin
            rr_nxt = int'(win) + 1;
            if (rr_nxt >= NCH) rr_nxt = 0;
            rr_ptr_n = GW'(rr_nxt);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge CLK) begin
        if (!RESn)
            rr_ptr <= '0;
        else if (CE)
            rr_ptr <= rr_ptr_n;
    end
`else
    // Fixed priority: lowest-index requesting channel wins
    always_comb begin
        win = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (CH_REQ[i]) win = GW'(i);
        end
    end
`endif

    // Route the winning channel's request fields
    always_comb begin
        sel_a   = '0;
        sel_do  = '0;
        sel_be  = '0;
        sel_wr  = 1'b0;
        sel_mrq = 1'b0;
        sel_st  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (win == GW'(i)) begin
                sel_a   = CH_A[32*i +: 32];
                sel_do  = CH_DO[32*i +: 32];
                sel_be  = CH_BE[4*i +: 4];
                sel_wr  = CH_WR[i];
                sel_mrq = CH_MRQ[i];
                sel_st  = CH_ST[2*i +: 2];
            end
        end
    end

    // Bus cycle sequencing and next values of every registered output
    always_comb begin
        state_n  = state;
        grant_n  = grant;
        be_hi_n  = be_hi;
        upper_n  = upper;
        a_n      = A;
        d_o_n    = D_O;
        ben_n    = BEn;
        st_n     = ST;
        dan_n    = DAn;
        mrqn_n   = MRQn;
        rw_n     = RW;
        bcystn_n = BCYSTn;
        ack_n    = '0;
        ch_di_n  = CH_DI;

        case (state)
            IDLE: begin
                if (req_any) begin
                    grant_n = win;
                    be_hi_n = sel_be[3:2];
                    if (sel_be == 4'h0) begin
                        // Nothing to transfer: acknowledge without a bus cycle
                        state_n = DONE;
                        ch_di_n = '0;
                        for (int i = 0; i < NCH; i++) begin
                            if (win == GW'(i)) ack_n[i] = 1'b1;
                        end
                    end else begin
                        a_n = sel_a;
                        if (sel_be[1:0] == 2'b00) a_n[1] = 1'b1;
                        upper_n  = (sel_be[1:0] == 2'b00);
                        d_o_n    = sel_do;
                        ben_n    = ~sel_be;
                        rw_n     = ~sel_wr;
                        mrqn_n   = ~sel_mrq;
                        st_n     = sel_st;
                        dan_n    = 1'b0;
                        bcystn_n = 1'b0;
                        state_n  = T1;
                    end
                end
            end
            T1: begin
                bcystn_n = 1'b1;
                state_n  = T2;
            end
            T2: begin
                if (!READYn) begin
                    if (RW) begin
                        for (int l = 0; l < 4; l++) begin
                            if (!BEn[l]) ch_di_n[8*l +: 8] = D_I[8*l +: 8];
                        end
                    end
                    if (!SZRQn && !upper && (be_hi != 2'b00)) begin
                        // Device is 16 bits wide: repeat for the upper half-word
                        a_n[1]   = 1'b1;
                        ben_n    = {~be_hi, 2'b11};
                        bcystn_n = 1'b0;
                        upper_n  = 1'b1;
                        state_n  = T1;
                    end else begin
                        dan_n   = 1'b1;
                        mrqn_n  = 1'b1;
                        ben_n   = 4'hF;
                        state_n = DONE;
                        for (int i = 0; i < NCH; i++) begin
                            if (grant == GW'(i)) ack_n[i] = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                dan_n   = 1'b1;
                mrqn_n  = 1'b1;
                ben_n   = 4'hF;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset wins over CE
    always_ff @(posedge CLK) begin
        if (!RESn) begin
            state  <= IDLE;
            grant  <= '0;
            be_hi  <= '0;
            upper  <= 1'b0;
            A      <= '0;
            D_O    <= '0;
            BEn    <= 4'hF;
            ST     <= 2'b00;
            DAn    <= 1'b1;
            MRQn   <= 1'b1;
            RW     <= 1'b1;
            BCYSTn <= 1'b1;
            CH_ACK <= '0;
            CH_DI  <= '0;
        end else if (CE) begin
            state  <= state_n;
            grant  <= grant_n;
            be_hi  <= be_hi_n;
            upper  <= upper_n;
            A      <= a_n;
            D_O    <= d_o_n;
            BEn    <= ben_n;
            ST     <= st_n;
            DAn    <= dan_n;
            MRQn   <= mrqn_n;
            RW     <= rw_n;
            BCYSTn <= bcystn_n;
            CH_ACK <= ack_n;
            CH_DI  <= ch_di_n;
        end
    end

endmodule

// File: tb/tb_v810_busarb.sv
// tb_v810_busarb: table-driven, randomized and hand-written sequences for
// v810_busarb with NCH=2. The bench plays the requester and the bus device.
module tb_v810_busarb;

    localparam int NCH = 2;

    logic              CLK = 1'b0;
    logic              RESn, CE;
    logic [NCH-1:0]    CH_REQ, CH_WR, CH_MRQ, CH_ACK;
    logic [NCH*32-1:0] CH_A, CH_DO;
    logic [NCH*4-1:0]  CH_BE;
    logic [NCH*2-1:0]  CH_ST;
    logic [31:0]       CH_DI, A, D_I, D_O;
    logic [3:0]        BEn;
    logic [1:0]        ST;
    logic              DAn, MRQn, RW, BCYSTn, READYn, SZRQn;

    v810_busarb #(.NCH(NCH)) dut (
        .CLK(CLK), .RESn(RESn), .CE(CE),
        .CH_REQ(CH_REQ), .CH_A(CH_A), .CH_DO(CH_DO), .CH_BE(CH_BE),
        .CH_WR(CH_WR), .CH_MRQ(CH_MRQ), .CH_ST(CH_ST),
        .CH_ACK(CH_ACK), .CH_DI(CH_DI),
        .A(A), .D_I(D_I), .D_O(D_O), .BEn(BEn), .ST(ST), .DAn(DAn),
        .MRQn(MRQn), .RW(RW), .BCYSTn(BCYSTn), .READYn(READYn), .SZRQn(SZRQn)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        int          ch;
        logic [31:0] a;
        logic [31:0] dout;
        logic [3:0]  be;
        logic        wr;
        logic        mrq;
        logic [1:0]  st;
        int          w1;
        int          w2;
        logic        sz;
        logic [31:0] di1;
        logic [31:0] di2;
    } acc_t;

    typedef struct packed {
        int          lat;
        int          ncyc;
        logic [31:0] a1;
        logic [3:0]  ben1;
        logic [31:0] a2;
        logic [3:0]  ben2;
        logic [31:0] di;
    } exp_t;

    typedef struct packed {
        acc_t t;
        exp_t e;
    } vec_t;

    typedef struct packed {
        int             lat;
        int             ncyc;
        logic [31:0]    a1;
        logic [3:0]     ben1;
        logic           rw1;
        logic           mrqn1;
        logic [1:0]     st1;
        logic [31:0]    dout1;
        logic           dan1;
        logic [31:0]    a2;
        logic [3:0]     ben2;
        logic [31:0]    di;
        logic [NCH-1:0] ack;
        logic [NCH-1:0] ack_after;
        logic           dan_after;
    } obs_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_di;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic doReset(input logic ce_during);
        RESn = 1'b0;
        CE   = ce_during;
        tick();
        RESn = 1'b1;
        CE   = 1'b1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " A"}, A, 32'h0);
        checkOutput({tag, " D_O"}, D_O, 32'h0);
        checkOutput({tag, " BEn"}, {28'h0, BEn}, 32'hF);
        checkOutput({tag, " ST"}, {30'h0, ST}, 32'h0);
        checkOutput({tag, " DAn/MRQn/RW/BCYSTn"}, {28'h0, DAn, MRQn, RW, BCYSTn}, 32'hF);
        checkOutput({tag, " CH_ACK"}, {30'h0, CH_ACK}, 32'h0);
        checkOutput({tag, " CH_DI"}, CH_DI, 32'h0);
    endtask

    task automatic setChannel(input acc_t t, input logic req);
        CH_REQ[t.ch]          = req;
        CH_A[32*t.ch +: 32]   = t.a;
        CH_DO[32*t.ch +: 32]  = t.dout;
        CH_BE[4*t.ch +: 4]    = t.be;
        CH_WR[t.ch]           = t.wr;
        CH_MRQ[t.ch]          = t.mrq;
        CH_ST[2*t.ch +: 2]    = t.st;
    endtask

    function automatic logic [31:0] mergeLanes(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] en);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) if (en[l]) r[8*l +: 8] = nw[8*l +: 8];
        return r;
    endfunction

    // Transaction-level model: what one access should look like on the bus
    function automatic exp_t expectAccess(input acc_t t, input logic [31:0] prev);
        exp_t e;
        logic lo, hi, second;
        e    = '0;
        lo   = (t.be[1:0] != 2'b00);
        hi   = (t.be[3:2] != 2'b00);
        if (t.be == 4'h0) begin
            e.lat  = 1;
            e.ncyc = 0;
            e.di   = 32'h0;
        end else begin
            second = lo && hi && t.sz;
            e.a1   = lo ? t.a : (t.a | 32'h2);
            e.ben1 = ~t.be;
            e.a2   = t.a | 32'h2;
            e.ben2 = ~{t.be[3:2], 2'b00};
            e.ncyc = second ? 2 : 1;
            e.lat  = 3 + t.w1 + (second ? 2 + t.w2 : 0);
            e.di   = prev;
            if (!t.wr) begin
                e.di = mergeLanes(e.di, t.di1, t.be);
                if (second) e.di = mergeLanes(e.di, t.di2, {t.be[3:2], 2'b00});
            end
        end
        return e;
    endfunction

    // Issue one request and act as the bus device until ACK (bounded)
    task automatic applyStimulus(input acc_t t, output obs_t o);
        int cnt;
        bit active, done;
        o      = '0;
        o.lat  = -1;
        cnt    = 0;
        active = 0;
        done   = 0;
        setChannel(t, 1'b1);
        READYn = 1'b1;
        SZRQn  = 1'b1;
        for (int k = 1; k <= 80 && !done; k++) begin
            tick();
            READYn = 1'b1;
            SZRQn  = 1'b1;
            if (CH_ACK != '0) begin
                o.lat = k;
                o.ack = CH_ACK;
                o.di  = CH_DI;
                done  = 1;
            end else begin
                if (!BCYSTn) begin
                    o.ncyc++;
                    if (o.ncyc == 1) begin
                        o.a1 = A; o.ben1 = BEn; o.rw1 = RW; o.mrqn1 = MRQn;
                        o.st1 = ST; o.dout1 = D_O; o.dan1 = DAn;
                    end else begin
                        o.a2 = A; o.ben2 = BEn;
                    end
                    cnt    = ((o.ncyc == 1) ? t.w1 : t.w2) + 1;
                    active = 1;
                end else if (active && cnt > 0) begin
                    cnt--;
                end
                if (active && cnt == 0) begin
                    READYn = 1'b0;
                    D_I    = (o.ncyc == 1) ? t.di1 : t.di2;
                    SZRQn  = (o.ncyc == 1 && t.sz) ? 1'b0 : 1'b1;
                    active = 0;
                end
            end
        end
        setChannel(t, 1'b0);
        READYn = 1'b1;
        SZRQn  = 1'b1;
        if (done) begin
            tick();
            o.ack_after = CH_ACK;
            o.dan_after = DAn;
        end
    endtask

    task automatic checkAccess(input string tag, input acc_t t, input exp_t e, input obs_t o);
        checkOutput({tag, " latency"}, o.lat, e.lat);
        checkOutput({tag, " ack channel"}, {30'h0, o.ack}, 32'd1 << t.ch);
        checkOutput({tag, " ack one cycle"}, {30'h0, o.ack_after}, 32'h0);
        checkOutput({tag, " DAn idle after"}, {31'h0, o.dan_after}, 32'h1);
        checkOutput({tag, " CH_DI"}, o.di, e.di);
        checkOutput({tag, " bus cycles"}, o.ncyc, e.ncyc);
        if (e.ncyc >= 1) begin
            checkOutput({tag, " A first"}, o.a1, e.a1);
            checkOutput({tag, " BEn first"}, {28'h0, o.ben1}, {28'h0, e.ben1});
            checkOutput({tag, " RW/MRQn/DAn"}, {29'h0, o.rw1, o.mrqn1, o.dan1},
                        {29'h0, !t.wr, !t.mrq, 1'b0});
            checkOutput({tag, " ST"}, {30'h0, o.st1}, {30'h0, t.st});
            checkOutput({tag, " D_O"}, o.dout1, t.dout);
        end
        if (e.ncyc == 2) begin
            checkOutput({tag, " A second"}, o.a2, e.a2);
            checkOutput({tag, " BEn second"}, {28'h0, o.ben2}, {28'h0, e.ben2});
        end
    endtask

    initial begin
        vec_t        vecs[7];
        acc_t        t;
        exp_t        e;
        obs_t        o;
        logic [NCH-1:0] ack_seen;
        int          k_ack, grants, next_start, exp_ch;

        CH_REQ = '0; CH_A = '0; CH_DO = '0; CH_BE = '0;
        CH_WR = '0; CH_MRQ = '0; CH_ST = '0;
        D_I = '0; READYn = 1'b1; SZRQn = 1'b1; RESn = 1'b0; CE = 1'b1;

        // ch, a, dout, be, wr, mrq, st, w1, w2, sz, di1, di2 | lat, ncyc, a1, ben1, a2, ben2, di
        vecs[0] = '{'{0, 32'h0500_0004, 32'h0, 4'hF, 0, 1, 2'd2, 0, 0, 0, 32'h1234_5678, 32'h0},
                    '{3, 1, 32'h0500_0004, 4'h0, 32'h0, 4'h0, 32'h1234_5678}};
        vecs[1] = '{'{1, 32'h0000_0100, 32'hAABB_CCDD, 4'hF, 1, 1, 2'd1, 0, 0, 1, 32'h0, 32'h0},
                    '{5, 2, 32'h0000_0100, 4'h0, 32'h0000_0102, 4'h3, 32'h1234_5678}};
        vecs[2] = '{'{0, 32'h0000_2000, 32'h0, 4'hF, 0, 0, 2'd3, 3, 0, 0, 32'hDEAD_BEEF, 32'h0},
                    '{6, 1, 32'h0000_2000, 4'h0, 32'h0, 4'h0, 32'hDEAD_BEEF}};
        vecs[3] = '{'{1, 32'h0000_3000, 32'h0, 4'h0, 0, 1, 2'd0, 0, 0, 0, 32'h7777_7777, 32'h0},
                    '{1, 0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0}};
        vecs[4] = '{'{0, 32'h0000_4000, 32'h0, 4'hC, 0, 1, 2'd0, 0, 0, 1, 32'hCAFE_F00D, 32'h0},
                    '{3, 1, 32'h0000_4002, 4'h3, 32'h0, 4'h0, 32'hCAFE_0000}};
        vecs[5] = '{'{1, 32'h0000_5000, 32'h0, 4'h3, 0, 1, 2'd0, 0, 0, 1, 32'h1111_BEEF, 32'h0},
                    '{3, 1, 32'h0000_5000, 4'hC, 32'h0, 4'h0, 32'hCAFE_BEEF}};
        vecs[6] = '{'{0, 32'h0000_6000, 32'h0, 4'hF, 0, 1, 2'd1, 1, 2, 1, 32'h9999_AAAA, 32'h5555_7777},
                    '{8, 2, 32'h0000_6000, 4'h0, 32'h0000_6002, 4'h3, 32'h5555_AAAA}};

        doReset(1'b1);
        checkResetState("reset");

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].t, o);
            checkAccess($sformatf("vec%0d", i), vecs[i].t, vecs[i].e, o);
        end
        model_di = vecs[6].e.di;

        for (int i = 0; i < 40; i++) begin
            t.ch   = $urandom_range(0, NCH - 1);
            t.a    = $urandom() & 32'hFFFF_FFFC;
            t.dout = $urandom();
            t.be   = 4'($urandom_range(0, 15));
            t.wr   = 1'($urandom_range(0, 1));
            t.mrq  = 1'($urandom_range(0, 1));
            t.st   = 2'($urandom_range(0, 3));
            t.w1   = $urandom_range(0, 3);
            t.w2   = $urandom_range(0, 3);
            t.sz   = 1'($urandom_range(0, 1));
            t.di1  = $urandom();
            t.di2  = $urandom();
            e = expectAccess(t, model_di);
            applyStimulus(t, o);
            checkAccess($sformatf("rand%0d", i), t, e, o);
            model_di = e.di;
        end

        // CE low freezes the cycle mid-access and holds the ACK pulse
        t = '{1, 32'h0000_0700, 32'h0, 4'hF, 0, 1, 2'd0, 0, 0, 0, 32'h0BAD_CAFE, 32'h0};
        setChannel(t, 1'b1);
        READYn = 1'b0;
        D_I    = 32'h0BAD_CAFE;
        tick();
        CE = 1'b0;
        repeat (3) tick();
        checkOutput("ce freeze BCYSTn", {31'h0, BCYSTn}, 32'h0);
        checkOutput("ce freeze A", A, 32'h0000_0700);
        CE    = 1'b1;
        k_ack = 0;
        for (int k = 1; k <= 10 && k_ack == 0; k++) begin
            tick();
            if (CH_ACK != '0) k_ack = k;
        end
        checkOutput("ce resume latency", k_ack, 2);
        CE = 1'b0;
        setChannel(t, 1'b0);
        READYn = 1'b1;
        repeat (2) tick();
        checkOutput("ce hold ack", {30'h0, CH_ACK}, 32'h2);
        checkOutput("ce hold CH_DI", CH_DI, 32'h0BAD_CAFE);
        CE = 1'b1;
        tick();
        checkOutput("ce ack released", {30'h0, CH_ACK}, 32'h0);

        // Reset during T2 (with CE low) aborts the access without ACK
        t = '{0, 32'h0000_0800, 32'h0, 4'hF, 0, 1, 2'd1, 0, 0, 0, 32'h0, 32'h0};
        setChannel(t, 1'b1);
        repeat (3) tick();
        setChannel(t, 1'b0);
        doReset(1'b0);
        checkResetState("midT2");
        ack_seen = '0;
        repeat (4) begin
            tick();
            ack_seen |= CH_ACK;
        end
        checkOutput("no ack after reset", {30'h0, ack_seen}, 32'h0);
        t = '{0, 32'h0000_0900, 32'h0, 4'hF, 0, 1, 2'd0, 1, 0, 0, 32'h2468_ACE0, 32'h0};
        e = expectAccess(t, 32'h0);
        applyStimulus(t, o);
        checkAccess("post-reset", t, e, o);

        // Both channels request continuously; grant order follows arbitration mode
        doReset(1'b1);
        t = '{0, 32'h0000_0010, 32'h0, 4'hF, 0, 1, 2'd0, 0, 0, 0, 32'h0, 32'h0};
        setChannel(t, 1'b1);
        t = '{1, 32'h0000_0020, 32'h0, 4'hF, 0, 1, 2'd0, 0, 0, 0, 32'h0, 32'h0};
        setChannel(t, 1'b1);
        READYn     = 1'b0;
        grants     = 0;
        next_start = 0;
        for (int k = 0; k < 60 && grants < 4; k++) begin
            tick();
            if (CH_ACK != '0) begin
`ifdef V810_BUSARB_ROUND_ROBIN_EN
                exp_ch     = next_start;
                next_start = (exp_ch + 1) % NCH;
`else
                exp_ch = 0;
`endif
                checkOutput($sformatf("arb grant %0d", grants), {30'h0, CH_ACK}, 32'd1 << exp_ch);
                grants++;
            end
        end
        checkOutput("arb grant count", grants, 4);
        CH_REQ = '0;
        READYn = 1'b1;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
